// File: rtl/ref_trim_cal.sv
// Multi-channel successive-approximation trim calibrator for analog references.
// Binary-searches one trim code per selected channel from its synchronised comparator output.
module ref_trim_cal #(
    parameter int NCH    = 2,
    parameter int TRIM_W = 6,
    parameter int SETTLE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NCH-1:0]        ch_mask,
    input  logic [NCH-1:0]        cmp_in,
    input  logic                  wr_en,
    input  logic [2:0]            wr_ch,
    input  logic [TRIM_W-1:0]     wr_code,
    output logic [NCH*TRIM_W-1:0] trim_code,
    output logic                  busy,
    output logic                  done,
    output logic [NCH-1:0]        cal_ok,
    output logic [NCH-1:0]        rail
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BIT_W = (TRIM_W > 2) ? $clog2(TRIM_W) : 1;
    localparam int CNT_W = $clog2(SETTLE);
    localparam logic [TRIM_W-1:0] MID      = TRIM_W'(1 << (TRIM_W - 1));
    localparam logic [TRIM_W-1:0] ALL_ONES = '1;
    localparam logic [BIT_W-1:0]  TOP_BIT  = BIT_W'(TRIM_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_SAMPLE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NCH-1:0]      pend_q, pend_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TRIM_W-1:0]   code_q [NCH];
    logic [TRIM_W-1:0]   code_d [NCH];
    logic [NCH-1:0]      cal_ok_q, cal_ok_d;
    logic [NCH-1:0]      rail_q, rail_d;
    logic [NCH-1:0]      sync1_q, sync2_q;

    logic [CH_W-1:0]     low_ch;
    logic [TRIM_W-1:0]   cur_code;
    logic [TRIM_W-1:0]   nxt_code;
    logic                cur_cmp;
    logic [BIT_W-1:0]    bit_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            ch_q     <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            cal_ok_q <= '0;
            rail_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                code_q[c] <= MID;
            end
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            ch_q     <= ch_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            cal_ok_q <= cal_ok_d;
            rail_q   <= rail_d;
            sync1_q  <= cmp_in;
            sync2_q  <= sync1_q;
            for (int c = 0; c < NCH; c++) begin
                code_q[c] <= code_d[c];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ch_d     = ch_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        cal_ok_d = cal_ok_q;
        rail_d   = rail_q;
        code_d   = code_q;
        cur_code = '0;
        cur_cmp  = 1'b0;
        nxt_code = '0;
        bit_m1   = bit_q - 1'b1;

        // Scanning downward leaves the lowest pending channel selected.
        low_ch = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (pend_q[c]) begin
                low_ch = CH_W'(c);
            end
        end

        for (int c = 0; c < NCH; c++) begin
            if (int'(ch_q) == c) begin
                cur_code = code_q[c];
                cur_cmp  = sync2_q[c];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pend_d  = ch_mask;
                    state_d = S_NEXT;
                end else if (wr_en) begin
                    for (int c = 0; c < NCH; c++) begin
                        if (int'(wr_ch) == c) begin
                            code_d[c]   = wr_code;
                            cal_ok_d[c] = 1'b0;
                            rail_d[c]   = 1'b0;
                        end
                    end
                end
            end
            S_NEXT: begin
                if (|pend_q) begin
                    ch_d = low_ch;
                    for (int c = 0; c < NCH; c++) begin
                        if (int'(low_ch) == c) begin
                            pend_d[c] = 1'b0;
                        end
                    end
                    state_d = S_SELECT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SELECT: begin
                for (int c = 0; c < NCH; c++) begin
                    if (int'(ch_q) == c) begin
                        code_d[c]   = MID;
                        cal_ok_d[c] = 1'b0;
                        rail_d[c]   = 1'b0;
                    end
                end
                bit_d   = TOP_BIT;
                cnt_d   = CNT_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                // Comparator high means the trial overshot: drop the bit under test.
                nxt_code = cur_code;
                if (cur_cmp) begin
                    nxt_code[bit_q] = 1'b0;
                end
                if (bit_q != '0) begin
                    nxt_code[bit_m1] = 1'b1;
                    bit_d   = bit_m1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_NEXT;
                end
                for (int c = 0; c < NCH; c++) begin
                    if (int'(ch_q) == c) begin
                        code_d[c] = nxt_code;
                        if (bit_q == '0) begin
                            if (nxt_code == '0 || nxt_code == ALL_ONES) begin
                                rail_d[c] = 1'b1;
                            end else begin
                                cal_ok_d[c] = 1'b1;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done   = (state_q == S_DONE);
    assign cal_ok = cal_ok_q;
    assign rail   = rail_q;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_code
            assign trim_code[gi*TRIM_W +: TRIM_W] = code_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_ref_trim_cal.sv
// Bench for ref_trim_cal: comparator model closes the loop on the trim codes,
// table-driven calibrations, hand-written handshake/reset sequences and random runs.
module tb_ref_trim_cal;

    localparam int NCH  = 2;
    localparam int W    = 4;
    localparam int S    = 3;
    localparam int P    = 2 + W * (S + 1);
    localparam int MAXC = (1 << W) - 1;
    localparam int MID  = 1 << (W - 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [NCH-1:0] ch_mask = '0;
    logic [NCH-1:0] cmp_in;
    logic           wr_en = 1'b0;
    logic [2:0]     wr_ch = '0;
    logic [W-1:0]   wr_code = '0;
    logic [NCH*W-1:0] trim_code;
    logic           busy;
    logic           done;
    logic [NCH-1:0] cal_ok;
    logic [NCH-1:0] rail;

    int tgt [NCH];
    int m_code [NCH];
    logic [NCH-1:0] m_ok;
    logic [NCH-1:0] m_rail;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [NCH-1:0] mask;
        int t0;
        int t1;
        int e0;
        int e1;
        logic [NCH-1:0] eok;
        logic [NCH-1:0] erail;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    // Analog stand-in: comparator reads high when the live code exceeds the target.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cmp
            assign cmp_in[gi] = (int'(trim_code[gi*W +: W]) > tgt[gi]);
        end
    endgenerate

    ref_trim_cal #(.NCH(NCH), .TRIM_W(W), .SETTLE(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ch_mask   (ch_mask),
        .cmp_in    (cmp_in),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_code   (wr_code),
        .trim_code (trim_code),
        .busy      (busy),
        .done      (done),
        .cal_ok    (cal_ok),
        .rail      (rail)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp_code(input int target);
        if (target < 0) return 0;
        if (target > MAXC) return MAXC;
        return target;
    endfunction

    // Code driven during trial t of a binary search toward the target.
    function automatic int sar_trial(input int target, input int t);
        int code;
        int trial;
        code = 0;
        for (int k = 0; k < W; k++) begin
            trial = code + (1 << (W - 1 - k));
            if (k == t) return trial;
            if (trial <= target) code = trial;
        end
        return code;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) m_code[c] = MID;
        m_ok   = '0;
        m_rail = '0;
    endtask

    task automatic check_state(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_code%0d", tag, c), int'(trim_code[c*W +: W]), m_code[c]);
        end
        chk($sformatf("%s_cal_ok", tag), int'(cal_ok), int'(m_ok));
        chk($sformatf("%s_rail", tag), int'(rail), int'(m_rail));
        chk($sformatf("%s_busy", tag), int'(busy), 0);
        chk($sformatf("%s_done", tag), int'(done), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_write(input int ch, input int code);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_ch   = 3'(ch);
        wr_code = W'(code);
        @(negedge clk);
        wr_en = 1'b0;
        if (ch < NCH) begin
            m_code[ch] = code;
            m_ok[ch]   = 1'b0;
            m_rail[ch] = 1'b0;
        end
        $display("write ch=%0d code=%0d -> trim_code=%h cal_ok=%b", ch, code, trim_code, cal_ok);
        check_state("write");
    endtask

    // One calibration: checks every trial code in its slot, done timing, and final state.
    task automatic run_cal(input logic [NCH-1:0] mask, input bit poke, input bit collide);
        int pos [NCH];
        int m;
        int exp_j;
        int got_j;
        int ndone;
        int busy_at_done;
        int f;
        m = 0;
        got_j = -1;
        ndone = 0;
        busy_at_done = 1;
        for (int c = 0; c < NCH; c++) begin
            pos[c] = -1;
            if (mask[c]) begin
                pos[c] = m;
                m++;
            end
        end
        exp_j = 1 + m * P;
        @(negedge clk);
        start   = 1'b1;
        ch_mask = mask;
        if (collide) begin
            wr_en   = 1'b1;
            wr_ch   = 3'd1;
            wr_code = W'(3);
        end
        @(posedge clk);
        for (int j = 0; j <= exp_j + 4; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start   = 1'b0;
                ch_mask = '0;
                wr_en   = 1'b0;
                chk("busy_rise", int'(busy), 1);
            end
            if (poke && j == 3) begin
                start   = 1'b1;
                ch_mask = '1;
                wr_en   = 1'b1;
                wr_ch   = 3'd1;
                wr_code = W'(3);
            end
            if (poke && j == 4) begin
                start   = 1'b0;
                ch_mask = '0;
                wr_en   = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (pos[c] >= 0) begin
                    for (int t = 0; t < W; t++) begin
                        if (j == pos[c] * P + 2 + t * (S + 1)) begin
                            chk($sformatf("trial_ch%0d_t%0d", c, t),
                                int'(trim_code[c*W +: W]), sar_trial(tgt[c], t));
                        end
                    end
                end
            end
            if (done) begin
                ndone++;
                if (got_j < 0) begin
                    got_j = j;
                    busy_at_done = int'(busy);
                end
            end
        end
        chk("done_count", ndone, 1);
        chk("done_time", got_j, exp_j);
        chk("busy_at_done", busy_at_done, 0);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                f = clamp_code(tgt[c]);
                m_code[c] = f;
                m_ok[c]   = (f != 0 && f != MAXC);
                m_rail[c] = !(f != 0 && f != MAXC);
            end
        end
        $display("cal mask=%b tgt=%0d,%0d poke=%0d collide=%0d -> trim_code=%h cal_ok=%b rail=%b done@%0d",
                 mask, tgt[0], tgt[1], poke, collide, trim_code, cal_ok, rail, got_j);
        check_state("cal");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2'b01,  5,  9,  5,  8, 2'b01, 2'b00};
        vt[1] = '{2'b11,  5, 12,  5, 12, 2'b11, 2'b00};
        vt[2] = '{2'b01, 15,  9, 15,  8, 2'b00, 2'b01};
        vt[3] = '{2'b01, -1,  9,  0,  8, 2'b00, 2'b01};
        vt[4] = '{2'b10,  3,  0,  8,  0, 2'b00, 2'b10};
        vt[5] = '{2'b00,  3,  3,  8,  8, 2'b00, 2'b00};
        vt[6] = '{2'b10,  0, 14,  8, 14, 2'b10, 2'b00};
        vt[7] = '{2'b11,  1,  7,  1,  7, 2'b11, 2'b00};

        for (int c = 0; c < NCH; c++) tgt[c] = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_state("reset_release");

        for (int i = 0; i < 8; i++) begin
            apply_reset();
            tgt[0] = vt[i].t0;
            tgt[1] = vt[i].t1;
            run_cal(vt[i].mask, 1'b0, 1'b0);
            chk($sformatf("vec%0d_code0", i), int'(trim_code[0 +: W]), vt[i].e0);
            chk($sformatf("vec%0d_code1", i), int'(trim_code[W +: W]), vt[i].e1);
            chk($sformatf("vec%0d_cal_ok", i), int'(cal_ok), int'(vt[i].eok));
            chk($sformatf("vec%0d_rail", i), int'(rail), int'(vt[i].erail));
        end

        // start and wr_en while busy must both be ignored
        apply_reset();
        tgt[0] = 5;
        tgt[1] = 12;
        run_cal(2'b01, 1'b1, 1'b0);
        chk("poke_code1", int'(trim_code[W +: W]), MID);

        run_cal(2'b11, 1'b0, 1'b0);
        do_write(1, 3);
        chk("wr_code1", int'(trim_code[W +: W]), 3);
        chk("wr_clears_ok", int'(cal_ok), 1);
        do_write(5, 9);
        chk("wr_bad_ch_code0", int'(trim_code[0 +: W]), 5);

        tgt[0] = 9;
        tgt[1] = 2;
        run_cal(2'b01, 1'b0, 1'b1);
        chk("collide_code1", int'(trim_code[W +: W]), 3);
        run_cal(2'b00, 1'b0, 1'b0);

        // asynchronous reset in the middle of a search
        tgt[0] = 5;
        tgt[1] = 12;
        run_cal(2'b11, 1'b0, 1'b0);
        @(negedge clk);
        start   = 1'b1;
        ch_mask = 2'b11;
        @(negedge clk);
        start   = 1'b0;
        ch_mask = '0;
        repeat (10) @(negedge clk);
        chk("mid_run_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1 model_reset();
        check_state("async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_state("post_reset");

        for (int it = 0; it < 15; it++) begin
            logic [NCH-1:0] rmask;
            bit rpoke;
            bit rcol;
            if ($urandom_range(1, 0) == 1) begin
                do_write(int'($urandom_range(7, 0)), int'($urandom_range(MAXC, 0)));
            end
            for (int c = 0; c < NCH; c++) tgt[c] = int'($urandom_range(MAXC + 4, 0)) - 2;
            rmask = NCH'($urandom_range((1 << NCH) - 1, 0));
            rpoke = (rmask != '0) && ($urandom_range(2, 0) == 0);
            rcol  = ($urandom_range(2, 0) == 0);
            run_cal(rmask, rpoke, rcol);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
